// File: rtl/int_arbiter.sv
// Round-robin interrupt arbiter: latches source events, raises a single
// non-nesting request to the processor and tracks ack/eoi handshaking.
module int_arbiter #(
    parameter int unsigned          N_SRC    = 4,
    parameter int unsigned          VEC_W    = 2,
    parameter logic [N_SRC-1:0]     MASK_RST = '1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_SRC-1:0]  src_pulse,
    input  logic              int_ack,
    input  logic              eoi,
    input  logic              mask_we,
    input  logic [N_SRC-1:0]  mask_wdata,
    output logic              int_req,
    output logic [VEC_W-1:0]  vector,
    output logic              in_service,
    output logic [N_SRC-1:0]  pending,
    output logic [N_SRC-1:0]  mask
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ASSERT,
        S_SERVICE
    } state_t;

    state_t             r_state;
    logic [N_SRC-1:0]   r_pending;
    logic [N_SRC-1:0]   r_mask;
    logic               r_int_req;
    logic [VEC_W-1:0]   r_vector;
    logic               r_in_service;
    logic [VEC_W-1:0]   r_ptr;

    logic [N_SRC-1:0]   w_elig;
    logic               w_found;
    logic [VEC_W-1:0]   w_sel;
    logic               w_ack;
    logic               w_eoi;
    logic [N_SRC-1:0]   w_clr;
    logic [VEC_W-1:0]   w_ptr_next;

    assign w_elig = r_pending & r_mask;

    // Rotating search: lowest eligible index at or above ptr wins; if none,
    // wrap around to the lowest eligible index overall.
    always_comb begin
        logic             hi_found;
        logic [VEC_W-1:0] hi_sel;
        logic             lo_found;
        logic [VEC_W-1:0] lo_sel;
        hi_found = 1'b0;
        hi_sel   = '0;
        lo_found = 1'b0;
        lo_sel   = '0;
        for (int unsigned i = 0; i < N_SRC; i++) begin
            if (w_elig[i]) begin
                if (!lo_found) begin
                    lo_found = 1'b1;
                    lo_sel   = i[VEC_W-1:0];
                end
                if (!hi_found && (i >= 32'(r_ptr))) begin
                    hi_found = 1'b1;
                    hi_sel   = i[VEC_W-1:0];
                end
            end
        end
        w_found = lo_found;
        w_sel   = hi_found ? hi_sel : lo_sel;
    end

    assign w_ack      = (r_state == S_ASSERT) && int_ack;
    assign w_eoi      = (r_state == S_SERVICE) && eoi;
    assign w_clr      = w_ack ? (N_SRC'(1) << r_vector) : '0;
    assign w_ptr_next = (r_vector == VEC_W'(N_SRC - 1)) ? '0 : r_vector + VEC_W'(1);

    // New events are OR-ed in after the grant clear, so a same-cycle set wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pending <= '0;
            r_mask    <= MASK_RST;
        end else begin
            r_pending <= (r_pending & ~w_clr) | src_pulse;
            if (mask_we) begin
                r_mask <= mask_wdata;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_int_req    <= 1'b0;
            r_vector     <= '0;
            r_in_service <= 1'b0;
            r_ptr        <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_vector  <= w_sel;
                        r_int_req <= 1'b1;
                        r_state   <= S_ASSERT;
                    end
                end
                S_ASSERT: begin
                    if (w_ack) begin
                        r_int_req    <= 1'b0;
                        r_in_service <= 1'b1;
                        r_state      <= S_SERVICE;
                    end
                end
                S_SERVICE: begin
                    if (w_eoi) begin
                        r_in_service <= 1'b0;
                        r_ptr        <= w_ptr_next;
                        r_state      <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign int_req    = r_int_req;
    assign vector     = r_vector;
    assign in_service = r_in_service;
    assign pending    = r_pending;
    assign mask       = r_mask;

endmodule

// File: tb/tb_int_arbiter.sv
// Bench for int_arbiter: directed handshake scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural model.
module tb_int_arbiter;

    localparam int N  = 4;
    localparam int VW = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [N-1:0]  src_pulse = '0;
    logic          int_ack = 1'b0;
    logic          eoi = 1'b0;
    logic          mask_we = 1'b0;
    logic [N-1:0]  mask_wdata = '0;
    logic          int_req;
    logic [VW-1:0] vector;
    logic          in_service;
    logic [N-1:0]  pending;
    logic [N-1:0]  mask;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    int_arbiter #(.N_SRC(N), .VEC_W(VW), .MASK_RST(4'b1111)) dut (
        .clk        (clk),
        .rst        (rst),
        .src_pulse  (src_pulse),
        .int_ack    (int_ack),
        .eoi        (eoi),
        .mask_we    (mask_we),
        .mask_wdata (mask_wdata),
        .int_req    (int_req),
        .vector     (vector),
        .in_service (in_service),
        .pending    (pending),
        .mask       (mask)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a request is outstanding, a service is in progress,
    // or neither; the grant is the first eligible source at/after ptr modulo N.
    bit [N-1:0] m_pend;
    bit [N-1:0] m_mask;
    bit         m_req;
    bit         m_svc;
    int         m_vec;
    int         m_ptr;

    always @(posedge clk or posedge rst) begin
        bit [N-1:0] elig;
        int idx;
        if (rst) begin
            m_pend = '0;
            m_mask = 4'b1111;
            m_req  = 1'b0;
            m_svc  = 1'b0;
            m_vec  = 0;
            m_ptr  = 0;
        end else begin
            elig = m_pend & m_mask;
            if (m_req) begin
                if (int_ack) begin
                    m_pend[m_vec] = 1'b0;
                    m_req = 1'b0;
                    m_svc = 1'b1;
                end
            end else if (m_svc) begin
                if (eoi) begin
                    m_svc = 1'b0;
                    m_ptr = (m_vec + 1) % N;
                end
            end else begin
                for (int k = 0; k < N; k++) begin
                    idx = (m_ptr + k) % N;
                    if (!m_req && elig[idx]) begin
                        m_req = 1'b1;
                        m_vec = idx;
                    end
                end
            end
            m_pend = m_pend | src_pulse;
            if (mask_we) m_mask = mask_wdata;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_int_req",    32'(int_req),    32'(m_req));
            chk("m_vector",     32'(vector),     32'(m_vec));
            chk("m_in_service", 32'(in_service), 32'(m_svc));
            chk("m_pending",    32'(pending),    32'(m_pend));
            chk("m_mask",       32'(mask),       32'(m_mask));
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic pulse_src(input logic [N-1:0] p);
        src_pulse = p;
        tick();
        src_pulse = '0;
    endtask

    // Entered with int_req high; acks, ends service, then waits one more edge.
    task automatic handshake(input int exp_vec);
        chk("hs_req",  32'(int_req), 32'd1);
        chk("hs_vec",  32'(vector),  32'(exp_vec));
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        chk("hs_ack_req", 32'(int_req),    32'd0);
        chk("hs_ack_svc", 32'(in_service), 32'd1);
        chk("hs_ack_vec", 32'(vector),     32'(exp_vec));
        eoi = 1'b1;
        tick();
        eoi = 1'b0;
        chk("hs_eoi_svc", 32'(in_service), 32'd0);
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        tick();
        rst = 1'b0;
        chk_en = 1'b1;
        chk("rst_mask", 32'(mask), 32'hf);
        chk("rst_req",  32'(int_req), 32'd0);

        // Single source handshake
        pulse_src(4'b0010);
        chk("single_pend", 32'(pending), 32'h2);
        chk("single_noreq", 32'(int_req), 32'd0);
        tick();
        chk("single_req", 32'(int_req), 32'd1);
        handshake(1);
        chk("single_idle", 32'(int_req), 32'd0);
        chk("single_pend0", 32'(pending), 32'h0);

        // ptr is now 2: of sources 0..2, source 2 wins
        pulse_src(4'b0111);
        tick();
        handshake(2);
        chk("ptr3_vec0", 32'(vector), 32'd0);
        handshake(0);
        chk("ptr1_vec1", 32'(vector), 32'd1);
        handshake(1);
        chk("drained", 32'(int_req), 32'd0);

        // Reset in the middle of service
        pulse_src(4'b1000);
        tick();
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        chk("pre_rst_svc", 32'(in_service), 32'd1);
        rst = 1'b1;
        #1;
        chk("async_rst_svc",  32'(in_service), 32'd0);
        chk("async_rst_vec",  32'(vector),     32'd0);
        chk("async_rst_mask", 32'(mask),       32'hf);
        chk("async_rst_pend", 32'(pending),    32'h0);
        tick();
        rst = 1'b0;
        pulse_src(4'b0100);
        tick();
        chk("post_rst_req", 32'(int_req), 32'd1);
        chk("post_rst_vec", 32'(vector),  32'd2);
        do_reset();

        // Round robin from ptr=0
        pulse_src(4'b1011);
        tick();
        handshake(0);
        handshake(1);
        handshake(3);
        chk("rr_done", 32'(int_req), 32'd0);

        // Masking (ptr now 0)
        mask_we = 1'b1;
        mask_wdata = 4'b1110;
        tick();
        mask_we = 1'b0;
        chk("mask_wr", 32'(mask), 32'he);
        pulse_src(4'b0001);
        chk("masked_pend", 32'(pending), 32'h1);
        tick();
        tick();
        chk("masked_noreq", 32'(int_req), 32'd0);
        mask_we = 1'b1;
        mask_wdata = 4'b1111;
        tick();
        mask_we = 1'b0;
        tick();
        chk("unmask_req", 32'(int_req), 32'd1);
        handshake(0);

        // Set-wins collision on source 2 (ptr now 1)
        pulse_src(4'b0100);
        tick();
        chk("col_vec", 32'(vector), 32'd2);
        int_ack = 1'b1;
        src_pulse = 4'b0100;
        tick();
        int_ack = 1'b0;
        src_pulse = 4'b0001;
        tick();
        src_pulse = '0;
        chk("col_pend", 32'(pending), 32'h5);
        eoi = 1'b1;
        tick();
        eoi = 1'b0;
        tick();
        handshake(0);
        handshake(2);

        // Stray strobes in IDLE (ptr now 3)
        int_ack = 1'b1;
        eoi = 1'b1;
        tick();
        int_ack = 1'b0;
        eoi = 1'b0;
        chk("stray_svc", 32'(in_service), 32'd0);
        chk("stray_req", 32'(int_req), 32'd0);
        pulse_src(4'b1001);
        tick();
        handshake(3);
        handshake(0);

        // Randomized traffic
        for (int c = 0; c < 4000; c++) begin
            src_pulse  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : '0;
            int_ack    = ($urandom_range(0, 2) == 0);
            eoi        = ($urandom_range(0, 2) == 0);
            mask_we    = ($urandom_range(0, 19) == 0);
            mask_wdata = 4'($urandom);
            rst        = ($urandom_range(0, 499) == 0);
            tick();
        end
        rst = 1'b0;
        src_pulse = '0;
        int_ack = 1'b0;
        eoi = 1'b0;
        mask_we = 1'b0;
        tick();
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
